ssram_bsrr_bank: RTL

- Parametrised bank of DEPTH registers, each WIDTH bits, behind a single request/acknowledge port.
- Supports four atomic write modes: write, bit-set, bit-clear and bit-toggle.
- Every access returns the register's previous value.
- Hardware set inputs give sticky status bits; all registers also drive parallel outputs to the rest of the design.
- Replaces the tristate row/column register arrays. Data in, data out and decode are separate, binary and registered.

---
 rtl/ssram_bsrr_bank_if.sv | 25 ++
 rtl/ssram_bsrr_bank.sv | 105 ++++++++++
 2 files changed

// File: rtl/ssram_bsrr_bank_if.sv
// Request/acknowledge bus for the set/clear/toggle register bank.
// The master drives the request fields; the slave returns ack, err and the old value.
interface ssram_bsrr_bank_if #(
   parameter int WIDTH = 16,
   parameter int AW    = 4
);
   logic             req;
   logic             we;
   logic [1:0]       mode;
   logic [AW-1:0]    addr;
   logic [WIDTH-1:0] wdata;
   logic             ack;
   logic             err;
   logic [WIDTH-1:0] rdata;

   modport master (
      output req, we, mode, addr, wdata,
      input  ack, err, rdata
   );

   modport slave (
      input  req, we, mode, addr, wdata,
      output ack, err, rdata
   );
endinterface

// File: rtl/ssram_bsrr_bank.sv
// Bank of DEPTH x WIDTH registers with atomic write/set/clear/toggle access,
// sticky hardware set strobes and a parallel output of every register.
module ssram_bsrr_bank #(
   parameter int               WIDTH     = 16,
   parameter int               DEPTH     = 16,
   parameter int               AW        = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   ssram_bsrr_bank_if.slave         bus,
   input  logic [DEPTH*WIDTH-1:0]   hw_set_i,
   output logic [DEPTH*WIDTH-1:0]   q_o
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             err_q, err_d;

   logic             addr_ok_s;
   logic [AW-1:0]    idx_s;
   logic [WIDTH-1:0] cur_s;
   logic [WIDTH-1:0] mod_s;
   logic [WIDTH-1:0] hw_sel_s;

   // Address decode and the bitwise modify result for the selected register.
   always_comb begin
      addr_ok_s = (32'(bus.addr) < 32'(DEPTH));
      // Out-of-range addresses are steered to entry 0 so the read stays in bounds.
      idx_s     = addr_ok_s ? bus.addr : '0;
      cur_s     = regs_q[idx_s];
      hw_sel_s  = hw_set_i[int'(idx_s)*WIDTH +: WIDTH];
      case (bus.mode)
         2'b00:   mod_s = bus.wdata;
         2'b01:   mod_s = cur_s | bus.wdata;
         2'b10:   mod_s = cur_s & ~bus.wdata;
         2'b11:   mod_s = cur_s ^ bus.wdata;
         default: mod_s = bus.wdata;
      endcase
   end

   // Next-state logic: hardware sets every cycle, bus access only when IDLE sees req.
   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      for (int i = 0; i < DEPTH; i++) begin
         regs_d[i] = regs_q[i] | hw_set_i[i*WIDTH +: WIDTH];
      end
      case (state_q)
         ST_IDLE: begin
            if (bus.req) begin
               rdata_d = addr_ok_s ? cur_s : '0;
               err_d   = !addr_ok_s;
               if (bus.we && addr_ok_s) begin
                  // Set strobes win over a concurrent clear so no event is lost.
                  regs_d[idx_s] = mod_s | hw_sel_s;
               end else begin
                  regs_d[idx_s] = regs_q[idx_s] | hw_sel_s;
               end
               state_d = ST_ACK;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State, register array and response registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         rdata_q <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= RESET_VAL;
         end
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign bus.ack   = (state_q == ST_ACK);
   assign bus.err   = err_q;
   assign bus.rdata = rdata_q;

   for (genvar g = 0; g < DEPTH; g++) begin : g_q
      assign q_o[g*WIDTH +: WIDTH] = regs_q[g];
   end

endmodule
